// File: rtl/control_multiciclo.sv
// Multicycle RV32I control sequencer: owns the instruction register, steps each
// instruction through FETCH..WRITEBACK, stalls on memory, counts retirements, traps.
module control_multiciclo #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    output logic [31:0] ir_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        addr_sel_o,
    output logic        alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_src_o,
    output logic [31:0] instret_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
    output logic [2:0]  dbg_state_o
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd5;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [31:0] WAIT_LAST = 32'(MEM_TIMEOUT) - 32'd1;

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] wait_q;

    logic        mem_req, mem_we, addr_sel, alu_src_b, rf_we, pc_we;
    logic [1:0]  alu_op, wb_sel, pc_src;

    logic [6:0]  opcode;
    logic        is_opimm, is_op, is_load, is_store, is_branch, is_jal, is_jalr, is_legal;
    logic        timeout_hit;

    assign opcode    = ir_q[6:0];
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_legal  = is_opimm | is_op | is_load | is_store | is_branch | is_jal | is_jalr;

    // Only meaningful in a requesting state; ready on the same cycle always wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready_i && (wait_q == WAIT_LAST);

    // Memory handshake: mem_req_o, addr_sel_o and mem_we_o stay stable while
    // mem_ready_i is low; the first cycle with mem_ready_i high completes the transfer.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cause_d   = cause_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready_i) begin
                    ir_d    = instr_i;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                alu_src_b = is_opimm | is_load | is_store | is_jalr;
                alu_op    = (is_op | is_opimm) ? 2'b10 : (is_branch ? 2'b01 : 2'b00);
                if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_src  = branch_taken_i ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else if (is_load | is_store) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (mem_ready_i) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = is_load ? 2'b01 : ((is_jal | is_jalr) ? 2'b10 : 2'b00);
                pc_src  = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'h0000_0013;
            instret_q <= 32'd0;
            cause_q   <= CAUSE_NONE;
            wait_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cause_q <= cause_d;
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
            // Any state change clears the wait count, so each FETCH/MEMORY entry starts at 0.
            if (state_d != state_q) begin
                wait_q <= 32'd0;
            end else if (mem_req && !mem_ready_i) begin
                wait_q <= wait_q + 32'd1;
            end
        end
    end

    // Everything reads as zero while reset is asserted.
    assign ir_o         = rst_ni ? ir_q : 32'd0;
    assign mem_req_o    = rst_ni & mem_req;
    assign mem_we_o     = rst_ni & mem_we;
    assign addr_sel_o   = rst_ni & addr_sel;
    assign alu_src_b_o  = rst_ni & alu_src_b;
    assign alu_op_o     = rst_ni ? alu_op : 2'b00;
    assign rf_we_o      = rst_ni & rf_we;
    assign wb_sel_o     = rst_ni ? wb_sel : 2'b00;
    assign pc_we_o      = rst_ni & pc_we;
    assign pc_src_o     = rst_ni ? pc_src : 2'b00;
    assign instret_o    = rst_ni ? instret_q : 32'd0;
    assign trap_o       = rst_ni & (state_q == S_TRAP);
    assign trap_cause_o = rst_ni ? cause_q : 2'b00;
    assign dbg_state_o  = rst_ni ? state_q : 3'd0;

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle sequencer for the RV32I core: owns the instruction register and steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It drives the enables and selects for the PC, the unified memory port, the ALU operand muxes, the register file and the immediate generator (fed from `ir_o`). It stalls on a ready/request memory handshake, counts retired instructions and traps on illegal opcodes or memory timeout.

## Interface
- `MEM_TIMEOUT`, 16: consecutive not-ready cycles on a memory request that force a trap; 0 disables the timeout.
- `clk_i` in 1: clock; all state changes on rising edge.
- `rst_ni` in 1: synchronous, active-low reset.
- `instr_i` in 32: memory read data during FETCH.
- `mem_ready_i` in 1: memory completes the current request this cycle.
- `branch_taken_i` in 1: ALU compare result, valid in EXECUTE of a branch.
- `ir_o` out 32: registered instruction, to immediate generator and register file addresses.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: request is a write.
- `addr_sel_o` out 1: memory address, 0 = PC, 1 = ALU result.
- `alu_src_b_o` out 1: 0 = rs2, 1 = immediate.
- `alu_op_o` out 2: 00 add, 01 compare, 10 decode funct3/funct7.
- `rf_we_o` out 1: register file write enable.
- `wb_sel_o` out 2: 00 ALU, 01 memory data, 10 PC+4.
- `pc_we_o` out 1: PC update (retire strobe).
- `pc_src_o` out 2: 00 PC+4, 01 PC+imm, 10 {ALU[31:1],1'b0}.
- `instret_o` out 32: retired-instruction counter.
- `trap_o` out 1: core halted.
- `trap_cause_o` out 2: 00 none, 01 illegal opcode, 10 memory timeout.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH: `mem_req_o`=1, `addr_sel_o`=0. On `mem_ready_i`, IR<=`instr_i`, go to DECODE. Otherwise stay.
- DECODE: supported opcodes are 0010011, 0110011, 0000011, 0100011, 1100011, 1101111 and 1100111. Any other opcode goes to TRAP with cause 01. Supported opcodes go to EXECUTE.
- EXECUTE:
  - `alu_src_b_o`=1 for OP-IMM, LOAD, STORE and JALR; otherwise 0.
  - `alu_op_o` is 10 for OP/OP-IMM, 01 for BRANCH, 00 otherwise.
  - BRANCH retires here: `pc_we_o`=1, `pc_src_o`=01 if `branch_taken_i`, else 00. Next state is FETCH.
  - LOAD and STORE go to MEMORY. All others go to WRITEBACK.
- MEMORY: `mem_req_o`=1, `addr_sel_o`=1, `mem_we_o`=1 for STORE. Outputs are held until `mem_ready_i`.
  - LOAD goes to WRITEBACK.
  - STORE retires on the ready cycle (`pc_we_o`=1, `pc_src_o`=00) and goes to FETCH.
- WRITEBACK: `rf_we_o`=1, `pc_we_o`=1, next state FETCH.
  - `wb_sel_o`: 00 for OP/OP-IMM, 01 for LOAD, 10 for JAL/JALR.
  - `pc_src_o`: 01 for JAL, 10 for JALR, 00 otherwise.
- Retire: `instret_o` increments by 1 in every cycle with `pc_we_o`=1, wrapping 0xFFFFFFFF -> 0.
- Timeout: a wait counter clears when FETCH or MEMORY is entered and increments each cycle `mem_req_o`=1 and `mem_ready_i`=0.
  - The trap (cause 10) is taken when a not-ready cycle occurs with the counter at MEM_TIMEOUT-1.
  - `mem_ready_i`=1 always wins over the timeout.
- TRAP: all enables and `mem_req_o` are 0, `trap_o`=1. The cause is held and the block is left only by reset.

## Timing
- Outputs are Moore-style from state plus `ir_o`. Exceptions: `pc_src_o` for a branch follows `branch_taken_i`, and `pc_we_o` in STORE-MEMORY follows `mem_ready_i`, both combinationally.
- Reset (`rst_ni`=0 at an edge): state FETCH, IR=0x00000013, `instret_o`=0, trap cause 00, wait counter 0. While `rst_ni`=0 all outputs are forced to 0.
- Reset mid-operation abandons the instruction. No write or retire happens in the reset cycle.
- With zero-wait memory, cycles per instruction:
  - OP/OP-IMM/JAL/JALR: 4
  - BRANCH: 3
  - STORE: 4
  - LOAD: 5
- Each not-ready cycle adds one cycle in FETCH or MEMORY.

## Test plan
- Reset, then fetch 0x00500093 (ADDI) with `mem_ready_i`=1 -> DECODE at cycle 1, EXECUTE at cycle 2 with `alu_src_b_o`=1 and `alu_op_o`=10, WRITEBACK at cycle 3 with `rf_we_o`=1 and `pc_we_o`=1; `instret_o`=1 at cycle 4.
- 0x00000463 (BEQ) with `branch_taken_i`=1, then again with 0 -> `pc_we_o`=1 in EXECUTE with `pc_src_o` 01 then 00; 3 cycles each; `instret_o` +2.
- 0x00002103 (LW), `mem_ready_i` low for 3 MEMORY cycles -> `mem_req_o`=1, `addr_sel_o`=1, `mem_we_o`=0 held for 4 cycles; WRITEBACK has `wb_sel_o`=01; 8 cycles total.
- 0x00102023 (SW), then 0x010000EF (JAL) -> `mem_we_o`=1 in MEMORY with `pc_we_o` on the ready cycle; JAL WRITEBACK has `wb_sel_o`=10 and `pc_src_o`=01.
- Fetch 0xFFFFFFFF -> TRAP at cycle 2 with `trap_o`=1 and `trap_cause_o`=01; no `pc_we_o` and `instret_o` unchanged for 20 cycles; `rst_ni`=0 for one edge returns to FETCH.
- MEM_TIMEOUT=16, `mem_ready_i` held 0 in FETCH -> TRAP (cause 10) entered after exactly 16 request cycles. Repeat with ready on the 16th cycle -> no trap.
